// File: rtl/char_buf_scroll_engine.sv
// char_buf_scroll_engine: arbitrates SRAM port 2 between the VGA reader and a clear/scroll engine
module char_buf_scroll_engine #(
    parameter int WORDS_PER_ROW = 20,
    parameter int ROWS = 60,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            ctrl_address,
    input  logic                  ctrl_chipselect,
    input  logic                  ctrl_read,
    input  logic                  ctrl_write,
    input  logic [31:0]           ctrl_writedata,
    output logic [31:0]           ctrl_readdata,
    output logic                  irq,
    input  logic [ADDR_WIDTH-1:0] vid_address,
    input  logic                  vid_read,
    output logic [31:0]           vid_readdata,
    output logic                  vid_readdatavalid,
    output logic [ADDR_WIDTH-1:0] address2,
    output logic                  chipselect2,
    output logic                  write2,
    output logic [31:0]           writedata2,
    output logic [3:0]            byteenable2,
    output logic                  clken2,
    input  logic [31:0]           readdata2
);
    typedef enum logic [2:0] {IDLE, CLR, SCR_RD, SCR_CAP, SCR_WR, SCR_FILL, FIN} state_t;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(ROWS * WORDS_PER_ROW - 1);
    localparam logic [ADDR_WIDTH-1:0] COPY_LAST = ADDR_WIDTH'((ROWS - 1) * WORDS_PER_ROW - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW = ADDR_WIDTH'(WORDS_PER_ROW);
    state_t state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [31:0] hold, fill_word;
    logic [7:0] fill_char;
    logic done, irq_en, busy, grant, eng_wr, eng_req, wr_en, rd_en, unused_bits;
    always_comb begin
        busy = state != IDLE;
        grant = !vid_read;
        eng_wr = state == CLR || state == SCR_WR || state == SCR_FILL;
        // engine access is suppressed during reset so an aborted run leaves the next word untouched
        eng_req = !reset && (eng_wr || state == SCR_RD);
        wr_en = ctrl_chipselect && ctrl_write;
        rd_en = ctrl_chipselect && ctrl_read;
    end
    assign address2 = vid_read ? vid_address : state == SCR_RD ? ptr + ROW : ptr;
    assign chipselect2 = vid_read || eng_req;
    assign write2 = grant && eng_req && eng_wr;
    assign writedata2 = state == SCR_WR ? hold : fill_word;
    assign byteenable2 = 4'hF;
    assign clken2 = 1'b1;
    assign vid_readdata = readdata2;
    assign irq = done && irq_en;
    assign unused_bits = ^ctrl_writedata[31:8];
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr <= '0;
            hold <= '0;
            fill_word <= '0;
            fill_char <= 8'h20;
            done <= 1'b0;
            irq_en <= 1'b0;
            ctrl_readdata <= '0;
            vid_readdatavalid <= 1'b0;
        end else begin
            vid_readdatavalid <= vid_read;
            if (rd_en)
                ctrl_readdata <= ctrl_address == 2'd1 ? {30'b0, done, busy} :
                                 ctrl_address == 2'd2 ? {24'b0, fill_char} :
                                 ctrl_address == 2'd3 ? {31'b0, irq_en} : 32'b0;
            if (wr_en && ctrl_address == 2'd2) fill_char <= ctrl_writedata[7:0];
            if (wr_en && ctrl_address == 2'd3) irq_en <= ctrl_writedata[0];
            if (wr_en && ctrl_address == 2'd1 && ctrl_writedata[1]) done <= 1'b0;
            if (state == FIN) done <= 1'b1;
            // the word read last cycle belongs to the engine even if video owns this cycle
            if (state == SCR_CAP) hold <= readdata2;
            case (state)
                IDLE:
                    if (wr_en && ctrl_address == 2'd0 && ctrl_writedata[1:0] != 2'b00) begin
                        ptr <= '0;
                        fill_word <= {4{fill_char}};
                        state <= ctrl_writedata[0] ? CLR : SCR_RD;
                    end
                CLR, SCR_FILL:
                    if (grant) begin
                        ptr <= ptr + 1'b1;
                        if (ptr == LAST) state <= FIN;
                    end
                SCR_RD: if (grant) state <= SCR_CAP;
                SCR_CAP: state <= SCR_WR;
                SCR_WR:
                    if (grant) begin
                        ptr <= ptr + 1'b1;
                        state <= ptr == COPY_LAST ? SCR_FILL : SCR_RD;
                    end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_char_buf_scroll_engine.sv
// tb_char_buf_scroll_engine: random-data bench with an SRAM model and an array-level clear/scroll reference
module tb_char_buf_scroll_engine;
    localparam int N = 1200;
    localparam int R = 20;
    logic clk, reset;
    logic [1:0] ctrl_address;
    logic ctrl_chipselect, ctrl_read, ctrl_write;
    logic [31:0] ctrl_writedata, ctrl_readdata;
    logic irq;
    logic [10:0] vid_address;
    logic vid_read;
    logic [31:0] vid_readdata;
    logic vid_readdatavalid;
    logic [10:0] address2;
    logic chipselect2, write2, clken2;
    logic [31:0] writedata2;
    logic [3:0] byteenable2;
    logic [31:0] readdata2;
    logic [31:0] sram [0:2047];
    logic [31:0] ref_mem [0:2047];
    int n_cmp, n_err, vid_mode;

    char_buf_scroll_engine dut (
        .clk(clk), .reset(reset),
        .ctrl_address(ctrl_address), .ctrl_chipselect(ctrl_chipselect),
        .ctrl_read(ctrl_read), .ctrl_write(ctrl_write),
        .ctrl_writedata(ctrl_writedata), .ctrl_readdata(ctrl_readdata), .irq(irq),
        .vid_address(vid_address), .vid_read(vid_read),
        .vid_readdata(vid_readdata), .vid_readdatavalid(vid_readdatavalid),
        .address2(address2), .chipselect2(chipselect2), .write2(write2),
        .writedata2(writedata2), .byteenable2(byteenable2), .clken2(clken2),
        .readdata2(readdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (chipselect2 && clken2) begin
            if (write2) begin
                for (int b = 0; b < 4; b++)
                    if (byteenable2[b]) sram[address2][b*8 +: 8] = writedata2[b*8 +: 8];
            end else readdata2 <= sram[address2];
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ctrl_wr(input logic [1:0] a, input logic [31:0] d);
        ctrl_chipselect = 1'b1;
        ctrl_write = 1'b1;
        ctrl_address = a;
        ctrl_writedata = d;
        cyc();
        ctrl_chipselect = 1'b0;
        ctrl_write = 1'b0;
    endtask

    task automatic ctrl_rd(input logic [1:0] a, output logic [31:0] d);
        ctrl_chipselect = 1'b1;
        ctrl_read = 1'b1;
        ctrl_address = a;
        cyc();
        d = ctrl_readdata;
        ctrl_chipselect = 1'b0;
        ctrl_read = 1'b0;
    endtask

    task automatic preload_rand();
        for (int i = 0; i < 2048; i++) begin
            sram[i] = $urandom;
            ref_mem[i] = sram[i];
        end
    endtask

    task automatic model_clear(input logic [7:0] c);
        for (int i = 0; i < N; i++) ref_mem[i] = {4{c}};
    endtask

    task automatic model_scroll(input logic [7:0] c);
        for (int i = 0; i < N; i++) ref_mem[i] = (i < N - R) ? ref_mem[i + R] : {4{c}};
    endtask

    task automatic check_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < 2048; i++) if (sram[i] !== ref_mem[i]) bad++;
        chk(tag, 32'(bad), 32'd0);
    endtask

    task automatic wait_irq(input int lim, output int n);
        n = 0;
        while (!irq && n < lim) begin
            cyc();
            n++;
        end
        if (!irq) chk("irq_timeout", 32'(irq), 32'd1);
    endtask

    // video requester: random or held-high reads, each checked one cycle later
    initial begin
        logic pend;
        logic [31:0] vexp;
        vid_read = 1'b0;
        vid_address = '0;
        pend = 1'b0;
        vexp = '0;
        forever begin
            cyc();
            if (pend) begin
                chk("vid_valid", 32'(vid_readdatavalid), 32'd1);
                chk("vid_data", vid_readdata, vexp);
            end else if (vid_mode != 0) chk("vid_idle_valid", 32'(vid_readdatavalid), 32'd0);
            vid_read = vid_mode == 2 ? 1'b1 : vid_mode == 1 ? ($urandom_range(0, 3) == 0) : 1'b0;
            vid_address = 11'($urandom_range(0, N - 1));
            pend = vid_read;
            vexp = sram[vid_address];
        end
    end

    always @(negedge clk) begin
        if (vid_read) begin
            chk("vid_addr", 32'(address2), 32'(vid_address));
            chk("vid_no_wr", 32'(write2), 32'd0);
            chk("vid_cs", 32'(chipselect2), 32'd1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [7:0] c;
        int n;
        n_cmp = 0;
        n_err = 0;
        vid_mode = 0;
        reset = 1'b1;
        ctrl_address = '0;
        ctrl_chipselect = 1'b0;
        ctrl_read = 1'b0;
        ctrl_write = 1'b0;
        ctrl_writedata = '0;
        for (int i = 0; i < 2048; i++) sram[i] = '0;
        repeat (3) cyc();
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_cs2", 32'(chipselect2), 32'd0);
        chk("rst_wr2", 32'(write2), 32'd0);
        chk("rst_vvalid", 32'(vid_readdatavalid), 32'd0);
        chk("rst_rdata", ctrl_readdata, 32'd0);
        chk("rst_be_clken", {27'b0, byteenable2, clken2}, 32'h1F);
        reset = 1'b0;
        ctrl_rd(2'd1, d); chk("rst_status", d, 32'h0);
        ctrl_rd(2'd2, d); chk("rst_fill", d, 32'h20);
        ctrl_rd(2'd3, d); chk("rst_ctrl", d, 32'h0);

        preload_rand();
        ctrl_wr(2'd3, 32'd1);
        ctrl_wr(2'd2, 32'h41);
        ctrl_wr(2'd0, 32'd1);
        wait_irq(5000, n);
        chk("clr_cycles", 32'(n), 32'd1201);
        model_clear(8'h41);
        check_mem("clr_mem");
        ctrl_rd(2'd1, d); chk("clr_status", d, 32'h2);
        ctrl_rd(2'd0, d); chk("cmd_read", d, 32'h0);
        ctrl_wr(2'd1, 32'h2);
        ctrl_rd(2'd1, d); chk("done_w1c", d, 32'h0);
        chk("irq_after_w1c", 32'(irq), 32'd0);

        for (int i = 0; i < 2048; i++) begin
            sram[i] = 32'(i);
            ref_mem[i] = 32'(i);
        end
        c = 8'($urandom);
        ctrl_wr(2'd2, {24'hABCDEF, c});
        ctrl_wr(2'd0, 32'd2);
        wait_irq(8000, n);
        chk("scr_cycles", 32'(n), 32'd3561);
        model_scroll(c);
        check_mem("scr_mem");
        ctrl_wr(2'd1, 32'h2);

        preload_rand();
        c = 8'($urandom);
        ctrl_wr(2'd2, {24'h0, c});
        ctrl_wr(2'd0, 32'd2);
        #3 vid_mode = 2;
        repeat (50) @(posedge clk);
        #3 vid_mode = 1;
        wait_irq(20000, n);
        vid_mode = 0;
        repeat (2) cyc();
        model_scroll(c);
        check_mem("scr_vid_mem");
        ctrl_wr(2'd1, 32'h2);

        preload_rand();
        c = 8'($urandom);
        ctrl_wr(2'd2, {24'h0, c});
        ctrl_wr(2'd0, 32'd3);
        ctrl_rd(2'd1, d); chk("busy", d, 32'h1);
        ctrl_wr(2'd0, 32'd2);
        ctrl_wr(2'd0, 32'd1);
        wait_irq(5000, n);
        chk("cmd3_cycles", 32'(n + 3), 32'd1201);
        model_clear(c);
        check_mem("cmd3_mem");
        ctrl_wr(2'd3, 32'd0);
        chk("irq_gated", 32'(irq), 32'd0);
        ctrl_rd(2'd1, d); chk("done_sticky", d, 32'h2);
        ctrl_wr(2'd3, 32'd1);
        chk("irq_enabled", 32'(irq), 32'd1);
        ctrl_wr(2'd1, 32'h2);
        chk("irq_cleared", 32'(irq), 32'd0);

        preload_rand();
        c = 8'($urandom);
        ctrl_wr(2'd2, {24'h0, c});
        ctrl_wr(2'd0, 32'd1);
        repeat (500) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        ctrl_rd(2'd1, d); chk("abort_status", d, 32'h0);
        for (int i = 0; i < 500; i++) ref_mem[i] = {4{c}};
        check_mem("abort_mem");
        ctrl_rd(2'd2, d); chk("abort_fill", d, 32'h20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
